// File: rtl/alu_accumulator.sv
// Command/accumulator stage around a combinational 16-bit ALU: accepts a command,
// drives registered operands, captures the result and maintains an accumulator.
module alu_accumulator #(
    parameter int          CNT_W  = 8,
    parameter logic [3:0]  CLR_OP = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic             cmd_src_acc,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic [1:0]       alu_error,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [1:0]       res_error,
    output logic [31:0]      acc,
    output logic [1:0]       sticky_error,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;

    state_t state;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_error    <= '0;
            acc          <= '0;
            sticky_error <= '0;
            op_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a <= cmd_src_acc ? acc[15:0] : cmd_a;
                        alu_b <= cmd_b;
                        // The clear opcode never reaches the ALU, so alu_op keeps its last value.
                        if (cmd_op == CLR_OP) begin
                            res_data     <= '0;
                            res_error    <= '0;
                            acc          <= '0;
                            sticky_error <= '0;
                            res_valid    <= 1'b1;
                            state        <= OUT;
                        end else begin
                            alu_op <= cmd_op;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    res_data  <= alu_result;
                    res_error <= alu_error;
                    if (alu_error == '0) begin
                        acc <= alu_result;
                    end else begin
                        sticky_error <= sticky_error | alu_error;
                    end
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        op_count  <= op_count + CNT_W'(1);
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
